// File: rtl/audio_pkg.sv
// Shared definitions for the audio request arbiter.
//   - sound codes driven on seq_select (0 means "nothing selected yet")
//   - arbiter state enumeration
//   - priority encoder: highest set bit of the request vector wins
package audio_pkg;

    localparam int NUM_SOURCES = 6;

    typedef enum logic [2:0] {
        SND_NONE      = 3'd0,
        SND_PLAY      = 3'd1,
        SND_LEVEL_INC = 3'd2,
        SND_WORLD_INC = 3'd3,
        SND_LIFE_DECR = 3'd4,
        SND_WIN       = 3'd5,
        SND_LOSE      = 3'd6
    } sound_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] index;
    } prio_t;

    // Ascending scan so the last (highest) set bit overwrites earlier hits.
    function automatic prio_t prio_encode(input logic [NUM_SOURCES-1:0] vec);
        prio_t result;
        result.valid = 1'b0;
        result.index = 3'd0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (vec[i]) begin
                result.valid = 1'b1;
                result.index = 3'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/audio_cycle_counter.sv
// Up-counter shared by the playback watchdog and the inter-sound gap timer.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   clear        - synchronous reload to zero (has priority over enable)
//   enable       - advance by one per cycle
//   terminal     - compare value; the count saturates there and never wraps
//   at_terminal  - high while the count equals terminal
module audio_cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create order-dependent
    // simulation and a mismatch against synthesis.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != terminal)) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/audio_request_arbiter.sv
// Fixed-priority scheduler between game-event sources and the audio sequencer.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   req[5:0]    - one-cycle request pulses; bit i requests sound code i+1
//   flush       - drops every pending request (a same-cycle req survives)
//   seq_end     - one-cycle end-of-sequence pulse from the sequencer
//   seq_enable  - one-cycle start pulse to the sequencer
//   seq_select  - sound code, stable from the start pulse until PLAY is left
//   busy        - high in START, PLAY and GAP
//   timeout     - one-cycle pulse when the playback watchdog fires
module audio_request_arbiter
    import audio_pkg::*;
#(
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] req,
    input  logic                   flush,
    input  logic                   seq_end,
    output logic                   seq_enable,
    output logic [2:0]             seq_select,
    output logic                   busy,
    output logic                   timeout
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] pending_next;
    logic [NUM_SOURCES-1:0] grant_clear;
    prio_t                  pick;

    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_terminal;

    // Pending update: flush first, then the grant clear, then new requests,
    // so a request landing on a flush or a grant edge is never lost.
    // NOTE: every signal driven here gets a value on every path (defaults
    // first); a missing assignment would infer a latch.
    always_comb begin
        pick        = prio_encode(pending);
        grant_clear = '0;
        if ((state == ST_IDLE) && pick.valid) begin
            grant_clear[pick.index] = 1'b1;
        end
        pending_next = ((flush ? '0 : pending) & ~grant_clear) | req;
    end

    // One counter serves both timers: it is reloaded on entry to PLAY and to
    // GAP, and the terminal value follows the state it is timing.
    always_comb begin
        cnt_enable   = (state == ST_PLAY) || (state == ST_GAP);
        cnt_clear    = (state == ST_START) ||
                       ((state == ST_PLAY) && (seq_end || cnt_done));
        cnt_terminal = (state == ST_PLAY) ? TIMEOUT_LAST : GAP_LAST;
    end

    audio_cycle_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear),
        .enable      (cnt_enable),
        .terminal    (cnt_terminal),
        .at_terminal (cnt_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= '0;
            seq_select <= 3'd0;
            timeout    <= 1'b0;
        end else begin
            pending <= pending_next;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick.valid) begin
                        seq_select <= pick.index + 3'd1;
                        state      <= ST_START;
                    end
                end
                ST_START: state <= ST_PLAY;
                ST_PLAY: begin
                    // seq_end outranks a watchdog expiry in the same cycle.
                    if (seq_end) begin
                        state <= ST_GAP;
                    end else if (cnt_done) begin
                        timeout <= 1'b1;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign seq_enable = (state == ST_START);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_audio_request_arbiter.sv
// Directed, scoreboard-based bench for audio_request_arbiter.
// Expected sound codes are queued when requests are driven and popped when a
// start pulse appears. Inputs are driven and outputs sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_audio_request_arbiter;
    import audio_pkg::*;

    localparam int G = 10;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] req;
    logic       flush;
    logic       seq_end;
    logic       seq_enable;
    logic [2:0] seq_select;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_enable = 0;
    int n_timeout = 0;

    logic [2:0] exp_q[$];

    audio_request_arbiter #(
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .flush      (flush),
        .seq_end    (seq_end),
        .seq_enable (seq_enable),
        .seq_select (seq_select),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Edge counter plus pulse tallies, taken from the values held just before each edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (seq_enable === 1'b1) n_enable <= n_enable + 1;
        if (timeout === 1'b1) n_timeout <= n_timeout + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [5:0] v, output int edge_n);
        req = v;
        step();
        req = '0;
        edge_n = cyc;
    endtask

    task automatic pulse_seq_end(output int edge_n);
        seq_end = 1'b1;
        step();
        seq_end = 1'b0;
        edge_n = cyc;
    endtask

    // Waits (bounded) for a start pulse, scores its code, and returns the
    // edge that entered START. Leaves the bench in the first PLAY cycle.
    task automatic wait_grant(input int limit, output int g_edge);
        int n;
        logic [2:0] exp;
        n = 0;
        g_edge = -1;
        while ((seq_enable !== 1'b1) && (n < limit)) begin
            step();
            n++;
        end
        if (seq_enable === 1'b1) begin
            g_edge = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'(seq_select), 32'(SND_NONE));
            end else begin
                exp = exp_q.pop_front();
                check("grant_code", 32'(seq_select), 32'(exp));
            end
            check("busy_at_grant", 32'(busy), 32'd1);
            step();
            check("enable_one_cycle", 32'(seq_enable), 32'd0);
        end else begin
            check("grant_wait_expired", 32'd0, 32'd1);
        end
    endtask

    task automatic count_busy(input int limit, output int n);
        n = 0;
        while ((busy === 1'b1) && (n < limit)) begin
            n++;
            step();
        end
    endtask

    initial begin
        int r_edge, g_edge, e_edge, nb, base, guard;

        reset   = 1'b1;
        req     = '0;
        flush   = 1'b0;
        seq_end = 1'b0;
        repeat (3) step();
        check("rst_seq_enable", 32'(seq_enable), 32'd0);
        check("rst_seq_select", 32'(seq_select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Single request: grant one edge after the sampling edge, GAP of exactly G.
        pulse_req(6'b000010, r_edge);
        exp_q.push_back(SND_LEVEL_INC);
        wait_grant(20, g_edge);
        check("req_latency", 32'(g_edge - r_edge), 32'd1);
        repeat (19) step();
        pulse_seq_end(e_edge);
        check("state_gap", 32'(dut.state), 32'(ST_GAP));
        count_busy(5 * G, nb);
        check("gap_length", 32'(nb), 32'(G));
        check("idle_after_gap", 32'(dut.state), 32'(ST_IDLE));

        // Priority: one pulse of three sources, served lose, worldInc, play.
        repeat (3) step();
        pulse_req(6'b100101, r_edge);
        exp_q.push_back(SND_LOSE);
        exp_q.push_back(SND_WORLD_INC);
        exp_q.push_back(SND_PLAY);
        wait_grant(20, g_edge);
        check("prio_latency", 32'(g_edge - r_edge), 32'd1);
        for (int k = 0; k < 2; k++) begin
            repeat (4) step();
            pulse_seq_end(e_edge);
            wait_grant(5 * G, g_edge);
            check("end_to_grant", 32'(g_edge - e_edge), 32'(G + 1));
        end
        repeat (4) step();
        pulse_seq_end(e_edge);
        count_busy(5 * G, nb);
        check("prio_final_gap", 32'(nb), 32'(G));
        check("prio_pending_empty", 32'(dut.pending), 32'd0);
        check("prio_queue_empty", 32'(exp_q.size()), 32'd0);

        // Merge: three req[3] pulses during a PLAY of code 4 give one more grant.
        pulse_req(6'b001000, r_edge);
        exp_q.push_back(SND_LIFE_DECR);
        wait_grant(20, g_edge);
        for (int k = 0; k < 3; k++) begin
            pulse_req(6'b001000, r_edge);
            step();
        end
        exp_q.push_back(SND_LIFE_DECR);
        pulse_seq_end(e_edge);
        wait_grant(5 * G, g_edge);
        check("merge_end_to_grant", 32'(g_edge - e_edge), 32'(G + 1));
        repeat (3) step();
        pulse_seq_end(e_edge);
        count_busy(5 * G, nb);
        base = n_enable;
        repeat (30) step();
        check("merge_no_extra_grant", 32'(n_enable - base), 32'd0);

        // Watchdog: no seq_end, so PLAY spans T cycles and timeout follows.
        base = n_timeout;
        pulse_req(6'b010000, r_edge);
        exp_q.push_back(SND_WIN);
        wait_grant(20, g_edge);
        guard = 0;
        while ((timeout !== 1'b1) && (guard < 3 * T)) begin
            step();
            guard++;
        end
        check("timeout_delay", 32'(cyc - g_edge), 32'(T + 1));
        check("busy_at_timeout", 32'(busy), 32'd1);
        step();
        check("timeout_one_cycle", 32'(timeout), 32'd0);
        count_busy(5 * G, nb);
        check("timeout_gap", 32'(nb), 32'(G - 1));
        check("timeout_count", 32'(n_timeout - base), 32'd1);

        // seq_end one cycle before expiry, then exactly on it: no timeout either way.
        for (int k = 0; k < 2; k++) begin
            base = n_timeout;
            pulse_req(6'b010000, r_edge);
            exp_q.push_back(SND_WIN);
            wait_grant(20, g_edge);
            repeat (T - 2 + k) step();
            pulse_seq_end(e_edge);
            count_busy(5 * G, nb);
            check("late_end_gap", 32'(nb), 32'(G));
            check("late_end_no_timeout", 32'(n_timeout - base), 32'd0);
        end

        // Flush with a same-cycle req[0]: only code 1 remains pending.
        pulse_req(6'b000100, r_edge);
        exp_q.push_back(SND_WORLD_INC);
        wait_grant(20, g_edge);
        pulse_req(6'b011000, r_edge);
        check("pending_before_flush", 32'(dut.pending), 32'b011000);
        flush = 1'b1;
        req   = 6'b000001;
        step();
        flush = 1'b0;
        req   = '0;
        check("pending_after_flush", 32'(dut.pending), 32'b000001);
        exp_q.push_back(SND_PLAY);
        pulse_seq_end(e_edge);
        wait_grant(5 * G, g_edge);
        repeat (2) step();
        pulse_seq_end(e_edge);
        count_busy(5 * G, nb);
        check("flush_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in PLAY with a request still pending.
        pulse_req(6'b100000, r_edge);
        exp_q.push_back(SND_LOSE);
        wait_grant(20, g_edge);
        pulse_req(6'b000001, r_edge);
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_seq_enable", 32'(seq_enable), 32'd0);
        check("arst_seq_select", 32'(seq_select), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_pending", 32'(dut.pending), 32'd0);
        step();
        reset = 1'b0;
        base = n_enable;
        repeat (1000) step();
        check("no_grant_after_reset", 32'(n_enable - base), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
